sha1_stream_core: RTL and testbench

- Next-generation SHA-1 engine.
- Takes pre-padded 512-bit blocks as a stream of 32-bit big-endian words over a valid/ready handshake.
- Chains any number of blocks per message using explicit first/last framing.
- Parametrised rounds-per-cycle trades area against throughput.
- Sits between a word-stream source (host/DMA/FIFO) and a digest consumer; the successor to the fixed single-round, write_en-driven SHA-1 block.

---
 rtl/sha1_stream_core.sv | 177 +++++++++++++++++
 tb/tb_sha1_stream_core.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sha1_stream_core.sv
// SHA-1 engine fed with pre-padded 512-bit blocks as 32-bit big-endian words.
// Blocks are chained per message with first/last framing; RPC rounds run per clock.
module sha1_stream_core #(
  parameter int          RPC   = 1,
  parameter logic [31:0] IV_H0 = 32'h67452301,
  parameter logic [31:0] IV_H1 = 32'hEFCDAB89,
  parameter logic [31:0] IV_H2 = 32'h98BADCFE,
  parameter logic [31:0] IV_H3 = 32'h10325476,
  parameter logic [31:0] IV_H4 = 32'hC3D2E1F0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [31:0]  s_data,
  input  logic         s_first,
  input  logic         s_last,
  output logic         busy,
  output logic [159:0] digest,
  output logic         digest_valid
);

  generate
    if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 5)) begin : g_bad_rpc
      $error("sha1_stream_core: RPC must be 1, 2, 4 or 5");
    end
  endgenerate

  typedef enum logic [1:0] {LOAD, COMPUTE, UPDATE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  idx;
  logic [6:0]  t;
  logic        rdy_en;
  logic        last_flag;
  logic        accept;
  logic [31:0] h     [5];
  logic [31:0] h_sum [5];
  logic [31:0] wv    [16];
  logic [31:0] ext   [16+RPC];
  logic [31:0] a, b, c, d, e;
  logic [31:0] ra, rb, rc, rd, re, rt;
  logic [1:0]  grp;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] f_sel(input logic [1:0] g, input logic [31:0] x,
                                        input logic [31:0] y, input logic [31:0] z);
    case (g)
      2'd0:    return (x & y) | (~x & z);
      2'd2:    return (x & y) | (x & z) | (y & z);
      default: return x ^ y ^ z;
    endcase
  endfunction

  function automatic logic [31:0] k_sel(input logic [1:0] g);
    case (g)
      2'd0:    return 32'h5A827999;
      2'd1:    return 32'h6ED9EBA1;
      2'd2:    return 32'h8F1BBCDC;
      default: return 32'hCA62C1D6;
    endcase
  endfunction

  // s_ready stays low during the first cycle out of reset
  assign s_ready = (state == LOAD) && rdy_en;
  assign busy    = (state != LOAD);
  assign accept  = s_valid && s_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (accept && idx == 4'd15) state_nxt = COMPUTE;
      COMPUTE: if (t == 7'(80 - RPC)) state_nxt = UPDATE;
      UPDATE:  state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // RPC rounds per cycle; the window extension chains in-cycle schedule dependencies
  always_comb begin
    grp = (t < 7'd20) ? 2'd0 : (t < 7'd40) ? 2'd1 : (t < 7'd60) ? 2'd2 : 2'd3;
    for (int i = 0; i < 16; i++) ext[i] = wv[i];
    for (int j = 0; j < RPC; j++)
      ext[16+j] = rotl(ext[13+j] ^ ext[8+j] ^ ext[2+j] ^ ext[j], 1);
    ra = a; rb = b; rc = c; rd = d; re = e; rt = '0;
    for (int j = 0; j < RPC; j++) begin
      rt = rotl(ra, 5) + f_sel(grp, rb, rc, rd) + re + k_sel(grp) + ext[j];
      re = rd;
      rd = rc;
      rc = rotl(rb, 30);
      rb = ra;
      ra = rt;
    end
  end

  always_comb begin
    h_sum[0] = h[0] + a;
    h_sum[1] = h[1] + b;
    h_sum[2] = h[2] + c;
    h_sum[3] = h[3] + d;
    h_sum[4] = h[4] + e;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= LOAD;
      idx          <= '0;
      t            <= '0;
      rdy_en       <= 1'b0;
      last_flag    <= 1'b0;
      digest_valid <= 1'b0;
      digest       <= '0;
      h[0]         <= IV_H0;
      h[1]         <= IV_H1;
      h[2]         <= IV_H2;
      h[3]         <= IV_H3;
      h[4]         <= IV_H4;
    end else begin
      rdy_en <= 1'b1;
      state  <= state_nxt;
      case (state)
        LOAD: begin
          if (accept) begin
            idx <= idx + 4'd1;
            if (idx == 4'd0 && s_first) begin
              h[0]         <= IV_H0;
              h[1]         <= IV_H1;
              h[2]         <= IV_H2;
              h[3]         <= IV_H3;
              h[4]         <= IV_H4;
              digest_valid <= 1'b0;
            end
            if (idx == 4'd15) begin
              last_flag <= s_last;
              t         <= '0;
            end
          end
        end
        COMPUTE: t <= t + 7'(RPC);
        UPDATE: begin
          for (int i = 0; i < 5; i++) h[i] <= h_sum[i];
          if (last_flag) begin
            digest       <= {h_sum[0], h_sum[1], h_sum[2], h_sum[3], h_sum[4]};
            digest_valid <= 1'b1;
          end
          idx <= '0;
        end
        default: ;
      endcase
    end
  end

  // Datapath registers carry no reset; they are always loaded before use
  always_ff @(posedge clk) begin
    if (accept) begin
      wv[idx] <= s_data;
      if (idx == 4'd15) begin
        a <= h[0];
        b <= h[1];
        c <= h[2];
        d <= h[3];
        e <= h[4];
      end
    end else if (state == COMPUTE) begin
      for (int i = 0; i < 16; i++) wv[i] <= ext[i+RPC];
      a <= ra;
      b <= rb;
      c <= rc;
      d <= rd;
      e <= re;
    end
  end

endmodule

// File: tb/tb_sha1_stream_core.sv
// Directed bench for sha1_stream_core: four instances (RPC 1/2/4/5) share clock and reset
// and are exercised one at a time with known SHA-1 vectors and handshake corner cases.
module tb_sha1_stream_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         sv [4];
  logic [31:0]  sd [4];
  logic         sf [4];
  logic         sl [4];
  logic         sr [4];
  logic         bz [4];
  logic         dv [4];
  logic [159:0] dg [4];

  for (genvar k = 0; k < 4; k++) begin : g_dut
    sha1_stream_core #(.RPC(k == 0 ? 1 : k == 1 ? 2 : k == 2 ? 4 : 5)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .s_valid      (sv[k]),
      .s_ready      (sr[k]),
      .s_data       (sd[k]),
      .s_first      (sf[k]),
      .s_last       (sl[k]),
      .busy         (bz[k]),
      .digest       (dg[k]),
      .digest_valid (dv[k])
    );
  end

  localparam int ABC = 0;
  localparam int M36 = 16;
  localparam int TWO = 32;
  localparam logic [159:0] D_ABC = 160'ha9993e364706816aba3e25717850c26c9cd0d89d;
  localparam logic [159:0] D_M36 = 160'hd2985049a677bbc4b4e8dea3b89c4820e5668e3a;
  localparam logic [159:0] D_TWO = 160'h84983e441c3bd26ebaae4aa1f95129e5e54670f1;

  typedef struct {
    int           dut;
    int           base;
    int           nblk;
    logic [159:0] exp;
  } vec_t;

  logic [31:0] words [64];
  logic [31:0] m36_hdr [9] = '{32'h61626364, 32'h65666768, 32'h696a6b6c, 32'h6d6e6f70,
                               32'h71727374, 32'h75767778, 32'h797a3031, 32'h32333435,
                               32'h36373839};
  logic [31:0] two_hdr [14] = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                32'h6d6e6f70, 32'h6e6f7071};
  vec_t tbl [8];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic int rpc_of(input int k);
    case (k)
      0:       return 1;
      1:       return 2;
      2:       return 4;
      default: return 5;
    endcase
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic put_word(input int k, input logic [31:0] w, input logic f, input logic l,
                          input bit gaps, output int lowcnt);
    lowcnt = 0;
    if (gaps)
      for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) begin
        @(negedge clk);
        sv[k] = 1'b0;
        sd[k] = $urandom;
      end
    @(negedge clk);
    sv[k] = 1'b1; sd[k] = w; sf[k] = f; sl[k] = l;
    while (!sr[k] && lowcnt < 300) begin
      lowcnt++;
      @(negedge clk);
    end
    if (!sr[k]) begin
      n_tests++; n_fail++;
      $display("FAIL ready_timeout: dut %0d s_ready stayed 0, expected 1", k);
    end
    @(posedge clk);
  endtask

  // Framing bits on positions where they must be ignored are driven randomly
  task automatic send_block(input int k, input int base, input logic first, input logic last,
                            input bit gaps, output int low0);
    int lc;
    low0 = 0;
    for (int i = 0; i < 16; i++) begin
      put_word(k, words[base+i], (i == 0) ? first : 1'($urandom),
               (i == 15) ? last : 1'($urandom), gaps, lc);
      if (i == 0) low0 = lc;
    end
  endtask

  task automatic wait_ready(input int k);
    int cnt = 0;
    @(negedge clk);
    sv[k] = 1'b0;
    while (!sr[k] && cnt < 300) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic wait_digest(input int k, output int lat);
    lat = -1;
    for (int m = 1; m <= 300; m++) begin
      @(negedge clk);
      if (m == 1) sv[k] = 1'b0;
      if (dv[k]) begin
        lat = m - 1;
        break;
      end
    end
  endtask

  task automatic send_msg(input int k, input int base, input int nblk, input bit gaps,
                          output int lat);
    int lc;
    for (int b = 0; b < nblk; b++) begin
      if (b > 0) begin
        wait_ready(k);
        chk("mid_block_dv", 160'(dv[k]), 160'(0));
      end
      send_block(k, base + 16 * b, b == 0, b == nblk - 1, gaps, lc);
    end
    wait_digest(k, lat);
  endtask

  initial begin
    int lat, lc, cnt;
    for (int k = 0; k < 4; k++) begin
      sv[k] = 1'b0; sd[k] = '0; sf[k] = 1'b0; sl[k] = 1'b0;
    end
    for (int i = 0; i < 64; i++) words[i] = '0;
    words[ABC+0]  = 32'h61626380;
    words[ABC+15] = 32'h00000018;
    for (int i = 0; i < 9; i++) words[M36+i] = m36_hdr[i];
    words[M36+9]  = 32'h80000000;
    words[M36+15] = 32'h00000120;
    for (int i = 0; i < 14; i++) words[TWO+i] = two_hdr[i];
    words[TWO+14] = 32'h80000000;
    words[TWO+31] = 32'h000001c0;

    tbl[0] = '{dut: 0, base: ABC, nblk: 1, exp: D_ABC};
    tbl[1] = '{dut: 3, base: M36, nblk: 1, exp: D_M36};
    tbl[2] = '{dut: 0, base: TWO, nblk: 2, exp: D_TWO};
    tbl[3] = '{dut: 1, base: TWO, nblk: 2, exp: D_TWO};
    tbl[4] = '{dut: 2, base: TWO, nblk: 2, exp: D_TWO};
    tbl[5] = '{dut: 3, base: TWO, nblk: 2, exp: D_TWO};
    tbl[6] = '{dut: 2, base: ABC, nblk: 1, exp: D_ABC};
    tbl[7] = '{dut: 1, base: M36, nblk: 1, exp: D_M36};

    // Reset values
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk("reset_ctrl", 160'({sr[k], bz[k], dv[k]}), 160'(0));
      chk("reset_digest", dg[k], 160'(0));
    end
    rst_n = 1'b1;
    #1 chk("ready_reset_cycle", 160'(sr[0]), 160'(0));
    @(negedge clk);
    chk("ready_after_reset", 160'(sr[0]), 160'(1));

    // Table-driven messages
    for (int v = 0; v < 8; v++) begin
      send_msg(tbl[v].dut, tbl[v].base, tbl[v].nblk, 1'b0, lat);
      chk($sformatf("digest_v%0d", v), dg[tbl[v].dut], tbl[v].exp);
      chk($sformatf("latency_v%0d", v), 160'(lat), 160'(80 / rpc_of(tbl[v].dut) + 1));
    end

    // Back-to-back messages with s_valid held high, RPC=4
    send_block(2, ABC, 1'b1, 1'b1, 1'b0, lc);
    @(negedge clk);
    sv[2] = 1'b1; sd[2] = words[M36]; sf[2] = 1'b1; sl[2] = 1'b0;
    cnt = 0;
    while (!sr[2] && cnt < 300) begin
      cnt++;
      @(negedge clk);
    end
    chk("b2b_ready_low", 160'(cnt), 160'(21));
    chk("b2b_dv_held", 160'(dv[2]), 160'(1));
    chk("b2b_digest1", dg[2], D_ABC);
    @(posedge clk);
    #1 chk("b2b_dv_cleared", 160'(dv[2]), 160'(0));
    for (int i = 1; i < 16; i++) put_word(2, words[M36+i], 1'b0, i == 15, 1'b0, lc);
    wait_digest(2, lat);
    chk("b2b_digest2", dg[2], D_M36);
    chk("b2b_latency2", 160'(lat), 160'(21));

    // Random input gaps on the two-block message
    send_msg(3, TWO, 2, 1'b1, lat);
    chk("gaps_digest_rpc5", dg[3], D_TWO);
    send_msg(1, TWO, 2, 1'b1, lat);
    chk("gaps_digest_rpc2", dg[1], D_TWO);

    // Reset during COMPUTE of block 0, then resend
    send_block(0, TWO, 1'b1, 1'b0, 1'b0, lc);
    repeat (10) @(negedge clk);
    sv[0] = 1'b0;
    chk("busy_in_compute", 160'(bz[0]), 160'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_ctrl", 160'({sr[0], bz[0], dv[0]}), 160'(0));
    chk("async_reset_digest", dg[0], 160'(0));
    @(negedge clk);
    rst_n = 1'b1;
    send_msg(0, TWO, 2, 1'b0, lat);
    chk("resend_digest", dg[0], D_TWO);
    chk("resend_latency", 160'(lat), 160'(81));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
